// File: rtl/binary_counter_n_updown_load_pkg.sv
// Shared types and the operation decoder for the up/down counter with parallel load.
package binary_counter_n_updown_load_pkg;

  // Operation selected on a clock edge; one per priority level.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } cnt_op_e;

  // Priority decode: synchronous clear, then load, then count in the chosen direction.
  function automatic cnt_op_e decode_op(input logic sync_clr, input logic load,
                                        input logic count, input logic up);
    cnt_op_e op;
    op = OP_HOLD;
    if (sync_clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (count) begin
      op = up ? OP_INC : OP_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/binary_counter_n_updown_load_if.sv
// Control/data bundle between a counter stage and whatever drives and observes it.
interface binary_counter_n_updown_load_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] Data_in;
  logic [WIDTH-1:0] Limit;
  logic             Count;
  logic             Up;
  logic             Load;
  logic             Sync_clr;
  logic [WIDTH-1:0] A_count;
  logic             C_out;
  logic             Wrapped;
  logic             Zero;

  // Driver side: supplies controls, observes count and flags.
  modport master (
    output Data_in, Limit, Count, Up, Load, Sync_clr,
    input  A_count, C_out, Wrapped, Zero
  );

  // Counter side.
  modport slave (
    input  Data_in, Limit, Count, Up, Load, Sync_clr,
    output A_count, C_out, Wrapped, Zero
  );

endinterface

// File: rtl/binary_counter_n_updown_load_next.sv
// Combinational next-count, terminal detect and carry/borrow strobe for one counter stage.
module binary_counter_n_updown_load_next
  import binary_counter_n_updown_load_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_count_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             sync_clr_i,
  input  logic             load_i,
  input  logic             count_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] cnt_d_o,
  output logic             term_c_o,
  output logic             wrap_clr_c_o
);

  cnt_op_e op;

  // Next value per decoded operation; term flags the wrapping edge (carry up, borrow down).
  always_comb begin
    op       = decode_op(sync_clr_i, load_i, count_i, up_i);
    cnt_d_o  = a_count_i;
    term_c_o = 1'b0;
    case (op)
      OP_CLR:  cnt_d_o = '0;
      OP_LOAD: cnt_d_o = data_in_i;
      OP_INC: begin
        // >= so a value loaded or left above a lowered Limit wraps on the next up-count.
        if (a_count_i >= limit_i) begin
          cnt_d_o  = '0;
          term_c_o = 1'b1;
        end else begin
          cnt_d_o = a_count_i + WIDTH'(1);
        end
      end
      OP_DEC: begin
        if (a_count_i == '0) begin
          cnt_d_o  = limit_i;
          term_c_o = 1'b1;
        end else begin
          cnt_d_o = a_count_i - WIDTH'(1);
        end
      end
      default: cnt_d_o = a_count_i;
    endcase
  end

  // Clear and load both drop the sticky wrap flag.
  assign wrap_clr_c_o = (op == OP_CLR) || (op == OP_LOAD);

endmodule

// File: rtl/binary_counter_n_updown_load.sv
// WIDTH-bit up/down counter with parallel load, programmable terminal value,
// synchronous/asynchronous clear, carry/borrow strobe and sticky wrap flag.
module binary_counter_n_updown_load
  import binary_counter_n_updown_load_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                                 CLK,
  input  logic                                 Clear_b,
  binary_counter_n_updown_load_if.slave        cnt_if
);

  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrapped_q, wrapped_d;
  logic             term_c;
  logic             wrap_clr_c;

  binary_counter_n_updown_load_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .a_count_i    (cnt_q),
    .data_in_i    (cnt_if.Data_in),
    .limit_i      (cnt_if.Limit),
    .sync_clr_i   (cnt_if.Sync_clr),
    .load_i       (cnt_if.Load),
    .count_i      (cnt_if.Count),
    .up_i         (cnt_if.Up),
    .cnt_d_o      (cnt_d),
    .term_c_o     (term_c),
    .wrap_clr_c_o (wrap_clr_c)
  );

  // Sticky wrap flag: cleared by clear/load, set by any wrapping count.
  always_comb begin
    wrapped_d = wrapped_q;
    if (wrap_clr_c) begin
      wrapped_d = 1'b0;
    end else if (term_c) begin
      wrapped_d = 1'b1;
    end
  end

  // Count and flag registers; Clear_b forces the reset value immediately.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      cnt_q     <= RESET_CNT;
      wrapped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
    end
  end

  // C_out and Zero are combinational so a cascaded stage sees the strobe in the same cycle.
  assign cnt_if.A_count = cnt_q;
  assign cnt_if.Wrapped = wrapped_q;
  assign cnt_if.C_out   = term_c;
  assign cnt_if.Zero    = (cnt_q == '0);

endmodule

// File: tb/tb_binary_counter_n_updown_load.sv
// Directed bench: main counter (RESET_VAL=0) cascaded into a second stage (RESET_VAL=5).
module tb_binary_counter_n_updown_load;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  int   checks;
  int   errors;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       wr;
  } exp_t;

  exp_t sb_q[$];

  binary_counter_n_updown_load_if #(.WIDTH(4)) bus_a ();
  binary_counter_n_updown_load_if #(.WIDTH(4)) bus_b ();

  binary_counter_n_updown_load #(.WIDTH(4), .RESET_VAL(0)) u_a (
    .CLK     (clk),
    .Clear_b (rst_a_n),
    .cnt_if  (bus_a)
  );

  binary_counter_n_updown_load #(.WIDTH(4), .RESET_VAL(5)) u_b (
    .CLK     (clk),
    .Clear_b (rst_b_n),
    .cnt_if  (bus_b)
  );

  // Cascade: second stage advances once per terminal strobe of the first.
  assign bus_b.Count = bus_a.C_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk_v(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic step(input string tag, input logic [3:0] cnt, input logic wr);
    exp_t e;
    e.tag = tag;
    e.cnt = cnt;
    e.wr  = wr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk_v({e.tag, "_cnt"}, bus_a.A_count, e.cnt);
    chk_b({e.tag, "_wrapped"}, bus_a.Wrapped, e.wr);
  endtask

  // Combinational flags after inputs settle, before the next edge.
  task automatic cchk(input string tag, input logic cout, input logic zero);
    #1;
    chk_b({tag, "_cout"}, bus_a.C_out, cout);
    chk_b({tag, "_zero"}, bus_a.Zero, zero);
  endtask

  initial begin
    logic [3:0] cur_t [4];
    logic [3:0] nxt_t [4];
    logic       wr_t  [4];
    logic       exp_wr;
    logic [3:0] v;

    checks = 0;
    errors = 0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.Data_in = 4'd0; bus_a.Limit = 4'd15; bus_a.Count = 1'b0;
    bus_a.Up = 1'b1; bus_a.Load = 1'b0; bus_a.Sync_clr = 1'b0;
    bus_b.Data_in = 4'd0; bus_b.Limit = 4'd15;
    bus_b.Up = 1'b1; bus_b.Load = 1'b0; bus_b.Sync_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_v("reset_cnt", bus_a.A_count, 4'd0);
    chk_b("reset_wrapped", bus_a.Wrapped, 1'b0);
    chk_b("reset_zero", bus_a.Zero, 1'b1);
    chk_v("reset_b_cnt", bus_b.A_count, 4'd5);

    // 1: count to 7, async clear mid-cycle, resume from 0.
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    bus_a.Count = 1'b1;
    for (int i = 1; i <= 7; i++) step("t1_up", 4'(i), 1'b0);
    bus_a.Count = 1'b0;
    #3;
    rst_a_n = 1'b0;
    #1;
    chk_v("t1_async_cnt", bus_a.A_count, 4'd0);
    chk_b("t1_async_wrapped", bus_a.Wrapped, 1'b0);
    step("t1_held", 4'd0, 1'b0);
    rst_a_n = 1'b1;
    bus_a.Count = 1'b1;
    step("t1_resume", 4'd1, 1'b0);

    // 2: load 10, count to 15 and wrap.
    bus_a.Count = 1'b0;
    bus_a.Load = 1'b1;
    bus_a.Data_in = 4'd10;
    step("t2_load", 4'd10, 1'b0);
    bus_a.Load = 1'b0;
    bus_a.Count = 1'b1;
    bus_a.Up = 1'b1;
    for (int i = 10; i <= 15; i++) begin
      cchk("t2_flags", (i == 15), 1'b0);
      if (i == 15) step("t2_wrap", 4'd0, 1'b1);
      else step("t2_up", 4'(i + 1), 1'b0);
    end
    chk_v("t2_cascade", bus_b.A_count, 4'd6);

    // 3: decade counter over two full periods.
    bus_a.Sync_clr = 1'b1;
    bus_a.Limit = 4'd9;
    step("t3_sclr", 4'd0, 1'b0);
    bus_a.Sync_clr = 1'b0;
    exp_wr = 1'b0;
    v = 4'd0;
    for (int i = 0; i < 20; i++) begin
      cchk("t3_flags", (v == 4'd9), (v == 4'd0));
      if (v == 4'd9) begin
        exp_wr = 1'b1;
        v = 4'd0;
      end else begin
        v = v + 4'd1;
      end
      step("t3_up", v, exp_wr);
    end
    chk_v("t3_cascade", bus_b.A_count, 4'd8);

    // 4: down-count with Limit=5 after loading 2 (load beats count).
    bus_a.Up = 1'b0;
    bus_a.Limit = 4'd5;
    bus_a.Load = 1'b1;
    bus_a.Data_in = 4'd2;
    cchk("t4_load_flags", 1'b0, 1'b1);
    step("t4_load", 4'd2, 1'b0);
    bus_a.Load = 1'b0;
    cur_t = '{4'd2, 4'd1, 4'd0, 4'd5};
    nxt_t = '{4'd1, 4'd0, 4'd5, 4'd4};
    wr_t  = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cchk("t4_flags", (cur_t[i] == 4'd0), (cur_t[i] == 4'd0));
      step("t4_down", nxt_t[i], wr_t[i]);
    end

    // 5: wrap at A>=Limit, borrow from 0, then load/clear priority over count.
    bus_a.Up = 1'b1;
    bus_a.Limit = 4'd4;
    cchk("t5_carry", 1'b1, 1'b0);
    step("t5_carry", 4'd0, 1'b1);
    bus_a.Up = 1'b0;
    bus_a.Limit = 4'd15;
    cchk("t5_borrow", 1'b1, 1'b1);
    step("t5_borrow", 4'd15, 1'b1);
    bus_a.Up = 1'b1;
    bus_a.Load = 1'b1;
    bus_a.Data_in = 4'd3;
    cchk("t5_load_cnt", 1'b0, 1'b0);
    step("t5_load_cnt", 4'd3, 1'b0);
    bus_a.Count = 1'b0;
    bus_a.Data_in = 4'd15;
    step("t5_load15", 4'd15, 1'b0);
    bus_a.Count = 1'b1;
    bus_a.Sync_clr = 1'b1;
    bus_a.Data_in = 4'd9;
    cchk("t5_sclr_load", 1'b0, 1'b0);
    step("t5_sclr_load", 4'd0, 1'b0);
    bus_a.Sync_clr = 1'b0;
    bus_a.Load = 1'b0;
    chk_v("t5_cascade", bus_b.A_count, 4'd11);

    // 6: value above a lowered Limit, then Limit=0.
    bus_a.Count = 1'b0;
    bus_a.Load = 1'b1;
    bus_a.Data_in = 4'd8;
    step("t6_load8", 4'd8, 1'b0);
    bus_a.Load = 1'b0;
    bus_a.Count = 1'b1;
    bus_a.Limit = 4'd3;
    cchk("t6_above", 1'b1, 1'b0);
    step("t6_above", 4'd0, 1'b1);
    bus_a.Count = 1'b0;
    bus_a.Load = 1'b1;
    step("t6_reload8", 4'd8, 1'b0);
    bus_a.Load = 1'b0;
    bus_a.Count = 1'b1;
    bus_a.Up = 1'b0;
    step("t6_dec_above", 4'd7, 1'b0);
    bus_a.Up = 1'b1;
    bus_a.Limit = 4'd0;
    cchk("t6_lim0_a", 1'b1, 1'b0);
    step("t6_lim0_a", 4'd0, 1'b1);
    cchk("t6_lim0_b", 1'b1, 1'b1);
    step("t6_lim0_b", 4'd0, 1'b1);
    bus_a.Count = 1'b0;
    cchk("t6_lim0_idle", 1'b0, 1'b1);
    chk_v("t6_cascade", bus_b.A_count, 4'd14);

    // Second stage clears to its own reset value.
    rst_b_n = 1'b0;
    #1;
    chk_v("t6_resetval5", bus_b.A_count, 4'd5);
    rst_b_n = 1'b1;
    #5;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
